dig_ct_arb: RTL and testbench
=============================

DIG_CT_ARB -- requirements
Module: dig_ct_arb

Interface
REQ-001 Parameter: WAIT_CYC, 1, cycles from launch edge until the shared DigCt registered outputs are sampled; legal range 1..15.
REQ-002 Port: CLK  input  1  single clock, all state updates on rising edge.
REQ-003 Port: RST  input  1  asynchronous, active-high reset.
REQ-004 Port: REQ  input  3  per-requester request, bit i = requester i, level-held until its DONE.
REQ-005 Port: DATA0, DATA1, DATA2  input  5 each  requester operands; bit0..bit4 map to DigCt IN1..IN5.
REQ-006 Port: IN_BUS  output  5  operand driven to the shared DigCt IN1..IN5.
REQ-007 Port: RES_IN  input  3  DigCt OUT1..OUT3 on bits 0..2.
REQ-008 Port: GNT  output  3  one-hot grant, all-zero when idle.
REQ-009 Port: DONE  output  3  one-hot, one-cycle completion pulse.
REQ-010 Port: RESULT  output  3  captured DigCt result, valid while any DONE bit is high, held otherwise.
REQ-011 Port: BUSY  output  1  high in every state except IDLE.
REQ-012 Port: TXN_CNT  output  8  completed-transaction counter.

Function
REQ-013 FSM states: IDLE, ISSUE, WAIT, DONE; all state and outputs registered.
REQ-014 IDLE: GNT=0, IN_BUS=0, DONE=0; if REQ!=0 at a rising edge -> latch winner index and its DATA, go to ISSUE; else stay.
REQ-015 Arbitration: round-robin; priority order is last-granted+1, +2, last-granted (mod 3); reset value of last-granted = 2 so requester 0 wins first.
REQ-016 ISSUE: one cycle; GNT=onehot(winner), IN_BUS=latched operand; next state WAIT with wait counter loaded to WAIT_CYC-1.
REQ-017 WAIT: GNT and IN_BUS held; counter decrements per cycle; when counter==0, RESULT<=RES_IN and go to DONE.
REQ-018 DONE: one cycle; DONE=onehot(winner), GNT held, TXN_CNT+=1 (wraps 255->0); next state IDLE unconditionally.
REQ-019 Latency: DONE high in the cycle entered WAIT_CYC+1 edges after the edge that sampled REQ in IDLE; one transaction per WAIT_CYC+3 cycles max.
REQ-020 Operand is latched at grant; DATAi changes after grant do not affect IN_BUS.
REQ-021 REQ deassertion after grant does not abort; transaction completes and DONE still pulses.
REQ-022 Requester keeping REQ high through DONE is re-arbitrated in the following IDLE cycle at lowest priority.
REQ-023 Simultaneous REQ in IDLE: exactly one GNT bit per REQ-015; losers stay pending, no state kept for them.
REQ-024 REQ arriving while BUSY is ignored until IDLE; never preempts.
REQ-025 GNT and DONE never have more than one bit set; DONE bit always equals the GNT bit held in that cycle.

Reset
REQ-026 RST high: immediately state=IDLE, GNT=0, DONE=0, IN_BUS=0, RESULT=0, BUSY=0, TXN_CNT=0, last-granted=2, wait counter=0.
REQ-027 RST asserted mid-transaction discards it: no DONE pulse, TXN_CNT not incremented.
REQ-028 First arbitration occurs at the first rising edge after RST deasserts with REQ!=0.

Verification (bench uses behavioural DigCt on IN_BUS/RES_IN, WAIT_CYC=1)
REQ-029 REQ=001, DATA0=5'b00100 -> GNT=001 in ISSUE, IN_BUS=00100, DONE=001 two edges after grant edge, RESULT=3'b110, TXN_CNT=1.
REQ-030 REQ=111 held, DATA0=00000, DATA1=01000, DATA2=01100 -> grants 0,1,2,0 in order; RESULTs 111, 011, 110, 111; each DONE one cycle, 4 cycles apart.
REQ-031 Grant to 1 with DATA1=01000, DATA1 changed to 00100 during WAIT -> IN_BUS stays 01000, RESULT=3'b011.
REQ-032 RST pulsed during WAIT of requester 0 -> no DONE, all outputs 0, TXN_CNT=0; next REQ=011 grants requester 0.
REQ-033 256 back-to-back single-requester transactions -> TXN_CNT wraps to 0 on the 256th DONE.
REQ-034 WAIT_CYC=3, REQ=100, DATA2=00000 -> WAIT lasts 3 cycles, DONE=100 four edges after grant edge, RESULT=3'b111.

Source files
------------

// File: rtl/dig_ct_arb.sv
// Round-robin arbiter sharing one DigCt block among three requesters.
// Each grant issues the latched operand, waits WAIT_CYC cycles, then captures the result.
module dig_ct_arb #(
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] REQ,
  input  logic [4:0] DATA0,
  input  logic [4:0] DATA1,
  input  logic [4:0] DATA2,
  output logic [4:0] IN_BUS,
  input  logic [2:0] RES_IN,
  output logic [2:0] GNT,
  output logic [2:0] DONE,
  output logic [2:0] RESULT,
  output logic       BUSY,
  output logic [7:0] TXN_CNT
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYC - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] gnt_q, gnt_d;
  logic [2:0] done_q, done_d;
  logic [4:0] in_bus_q, in_bus_d;
  logic [2:0] result_q, result_d;
  logic       busy_q, busy_d;
  logic [7:0] txn_q, txn_d;
  logic [1:0] last_q, last_d;
  logic [3:0] cnt_q, cnt_d;

  logic [1:0] win;
  logic [2:0] win_oh;
  logic [4:0] win_data;

  // Search starts just after the last winner, so it ends up lowest priority.
  always_comb begin
    win = 2'd0;
    unique case (last_q)
      2'd0: win = REQ[1] ? 2'd1 : (REQ[2] ? 2'd2 : 2'd0);
      2'd1: win = REQ[2] ? 2'd2 : (REQ[0] ? 2'd0 : 2'd1);
      default: win = REQ[0] ? 2'd0 : (REQ[1] ? 2'd1 : 2'd2);
    endcase
  end

  always_comb begin
    win_oh   = 3'b001;
    win_data = DATA0;
    unique case (win)
      2'd1: begin
        win_oh   = 3'b010;
        win_data = DATA1;
      end
      2'd2: begin
        win_oh   = 3'b100;
        win_data = DATA2;
      end
      default: begin
        win_oh   = 3'b001;
        win_data = DATA0;
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    done_d   = 3'b000;
    in_bus_d = in_bus_q;
    result_d = result_q;
    busy_d   = busy_q;
    txn_d    = txn_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (|REQ) begin
          state_d  = S_ISSUE;
          gnt_d    = win_oh;
          in_bus_d = win_data;
          last_d   = win;
          busy_d   = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = CNT_LOAD;
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_DONE;
          result_d = RES_IN;
          done_d   = gnt_q;
          txn_d    = txn_q + 8'd1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d  = S_IDLE;
        gnt_d    = 3'b000;
        in_bus_d = 5'b00000;
        busy_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      gnt_q    <= 3'b000;
      done_q   <= 3'b000;
      in_bus_q <= 5'b00000;
      result_q <= 3'b000;
      busy_q   <= 1'b0;
      txn_q    <= 8'd0;
      last_q   <= 2'd2;
      cnt_q    <= 4'd0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      in_bus_q <= in_bus_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      txn_q    <= txn_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

  assign GNT     = gnt_q;
  assign DONE    = done_q;
  assign IN_BUS  = in_bus_q;
  assign RESULT  = result_q;
  assign BUSY    = busy_q;
  assign TXN_CNT = txn_q;

endmodule

// File: tb/tb_dig_ct_arb.sv
// Scoreboard bench for dig_ct_arb with a registered behavioural DigCt.
// Instances: WAIT_CYC=1 (main) and WAIT_CYC=3.
module tb_dig_ct_arb;

  typedef struct {
    logic [2:0] done;
    logic [2:0] res;
    logic [7:0] txn;
    int         cyc;
  } exp_t;

  logic       CLK;
  logic       RST;
  logic [2:0] req, req3;
  logic [4:0] d0, d1, d2, d0_3, d1_3, d2_3;
  logic [4:0] in_bus, in_bus3;
  logic [2:0] res_in, res_in3;
  logic [2:0] gnt, gnt3, done, done3, result, result3;
  logic       busy, busy3;
  logic [7:0] txn, txn3;

  exp_t q1[$];
  exp_t q3[$];
  int   n_run;
  int   n_fail;
  int   cyc;
  int   c;

  dig_ct_arb #(.WAIT_CYC(1)) dut (
    .CLK(CLK), .RST(RST), .REQ(req),
    .DATA0(d0), .DATA1(d1), .DATA2(d2),
    .IN_BUS(in_bus), .RES_IN(res_in),
    .GNT(gnt), .DONE(done), .RESULT(result),
    .BUSY(busy), .TXN_CNT(txn)
  );

  dig_ct_arb #(.WAIT_CYC(3)) dut3 (
    .CLK(CLK), .RST(RST), .REQ(req3),
    .DATA0(d0_3), .DATA1(d1_3), .DATA2(d2_3),
    .IN_BUS(in_bus3), .RES_IN(res_in3),
    .GNT(gnt3), .DONE(done3), .RESULT(result3),
    .BUSY(busy3), .TXN_CNT(txn3)
  );

  // Behavioural DigCt: OUT1=~IN3, OUT2=1, OUT3=IN3|~IN4, registered.
  function automatic logic [2:0] digct(input logic [4:0] x);
    return {x[2] | ~x[3], 1'b1, ~x[2]};
  endfunction

  always @(posedge CLK) begin
    res_in  <= digct(in_bus);
    res_in3 <= digct(in_bus3);
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc++;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push1(input logic [2:0] dn, input logic [2:0] r,
                       input logic [7:0] t, input int cy);
    exp_t e;
    e.done = dn; e.res = r; e.txn = t; e.cyc = cy;
    q1.push_back(e);
  endtask

  always @(negedge CLK) begin
    if (!RST && done != 3'b000) begin
      if (q1.size() == 0) begin
        check("unexpected_done", {29'd0, done}, 32'd0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("done_bit", {29'd0, done}, {29'd0, e.done});
        check("done_eq_gnt", {29'd0, done}, {29'd0, gnt});
        check("result", {29'd0, result}, {29'd0, e.res});
        check("txn_cnt", {24'd0, txn}, {24'd0, e.txn});
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge CLK) begin
    if (!RST && done3 != 3'b000) begin
      if (q3.size() == 0) begin
        check("unexpected_done3", {29'd0, done3}, 32'd0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("done3_bit", {29'd0, done3}, {29'd0, e.done});
        check("result3", {29'd0, result3}, {29'd0, e.res});
        check("txn3_cnt", {24'd0, txn3}, {24'd0, e.txn});
        check("done3_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset_outs", {8'd0, gnt, done, in_bus, result, busy, txn},
          32'd0);
    RST = 1'b0;
  endtask

  initial begin
    n_run = 0; n_fail = 0;
    RST = 1'b1;
    req = 3'b000; req3 = 3'b000;
    d0 = '0; d1 = '0; d2 = '0;
    d0_3 = '0; d1_3 = '0; d2_3 = '0;

    // single transaction right after reset
    do_reset();
    @(negedge CLK); c = cyc;
    req = 3'b001; d0 = 5'b00100;
    push1(3'b001, 3'b110, 8'd1, c + 3);
    @(negedge CLK);
    check("issue_gnt", {29'd0, gnt}, 32'b001);
    check("issue_bus", {27'd0, in_bus}, 32'b00100);
    check("issue_busy", {31'd0, busy}, 32'd1);
    repeat (2) @(negedge CLK);
    req = 3'b000;
    repeat (2) @(negedge CLK);
    check("idle_outs", {20'd0, gnt, done, in_bus, busy}, 32'd0);

    // three requesters held: round robin 0,1,2,0
    do_reset();
    @(negedge CLK); c = cyc;
    req = 3'b111; d0 = 5'b00000; d1 = 5'b01000; d2 = 5'b01100;
    push1(3'b001, 3'b111, 8'd1, c + 3);
    push1(3'b010, 3'b011, 8'd2, c + 7);
    push1(3'b100, 3'b110, 8'd3, c + 11);
    push1(3'b001, 3'b111, 8'd4, c + 15);
    for (int k = 0; k < 4; k++) begin
      logic [2:0] eg;
      logic [4:0] eb;
      eg = (k == 1) ? 3'b010 : (k == 2) ? 3'b100 : 3'b001;
      eb = (k == 1) ? 5'b01000 : (k == 2) ? 5'b01100 : 5'b00000;
      @(negedge CLK);
      check("rr_gnt", {29'd0, gnt}, {29'd0, eg});
      check("rr_bus", {27'd0, in_bus}, {27'd0, eb});
      repeat (3) @(negedge CLK);
    end
    req = 3'b000;
    repeat (2) @(negedge CLK);

    // operand latched at grant, no preemption while busy
    @(negedge CLK); c = cyc;
    req = 3'b010; d1 = 5'b01000;
    push1(3'b010, 3'b011, 8'd5, c + 3);
    @(negedge CLK);
    check("t3_gnt", {29'd0, gnt}, 32'b010);
    @(negedge CLK);
    d1 = 5'b00100; req = 3'b011;
    @(negedge CLK);
    check("t3_bus_held", {27'd0, in_bus}, 32'b01000);
    check("t3_no_preempt", {29'd0, gnt}, 32'b010);
    req = 3'b001;
    push1(3'b001, 3'b111, 8'd6, c + 7);
    repeat (2) @(negedge CLK);
    check("t3_next_gnt", {29'd0, gnt}, 32'b001);
    repeat (2) @(negedge CLK);
    req = 3'b000;
    repeat (2) @(negedge CLK);

    // reset during WAIT discards the transaction
    @(negedge CLK);
    req = 3'b001; d0 = 5'b00100;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    #1;
    check("midrst_outs", {8'd0, gnt, done, in_bus, result, busy, txn},
          32'd0);
    req = 3'b000;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK); c = cyc;
    req = 3'b011;
    push1(3'b001, 3'b110, 8'd1, c + 3);
    @(negedge CLK);
    check("post_rst_gnt", {29'd0, gnt}, 32'b001);
    repeat (2) @(negedge CLK);
    req = 3'b000;
    repeat (2) @(negedge CLK);

    // 256 back-to-back transactions, counter wraps to 0
    do_reset();
    @(negedge CLK); c = cyc;
    req = 3'b001; d0 = 5'b00100;
    for (int k = 0; k < 256; k++)
      push1(3'b001, 3'b110, 8'(k + 1), c + 3 + 4 * k);
    repeat (1023) @(negedge CLK);
    req = 3'b000;
    repeat (2) @(negedge CLK);
    check("wrap_cnt", {24'd0, txn}, 32'd0);

    // WAIT_CYC=3 instance
    @(negedge CLK); c = cyc;
    req3 = 3'b100; d2_3 = 5'b00000;
    begin
      exp_t e;
      e.done = 3'b100; e.res = 3'b111; e.txn = 8'd1; e.cyc = c + 5;
      q3.push_back(e);
    end
    @(negedge CLK);
    check("w3_gnt", {29'd0, gnt3}, 32'b100);
    repeat (3) @(negedge CLK);
    check("w3_still_wait", {29'd0, done3}, 32'd0);
    @(negedge CLK);
    req3 = 3'b000;
    repeat (3) @(negedge CLK);

    check("q1_drained", q1.size(), 32'd0);
    check("q3_drained", q3.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
